// File: rtl/dsi_lanes_ctrl.sv
// MIPI DSI data/clock lane controller: LP sequencing, HS byte striping over 1..4 lanes.
// Define DSI_LANES_CTRL_TRAIL_EN to emit HS-trail after each packet.
module dsi_lanes_ctrl #(
  parameter int T_INIT    = 100,
  parameter int T_LPX     = 4,
  parameter int T_HS_ZERO = 6,
  parameter int T_TRAIL   = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [31:0] iface_write_data,
  input  logic [3:0]  iface_write_strb,
  input  logic        iface_write_rqst,
  input  logic        iface_last_word,
  output logic        iface_data_rqst,
  input  logic        iface_lpm_en,
  input  logic [1:0]  reg_lanes_number,
  input  logic        lines_enable,
  input  logic        clock_enable,
  output logic        lines_ready,
  output logic        clock_ready,
  output logic [31:0] hs_lane_output,
  output logic [3:0]  LP_p_output,
  output logic [3:0]  LP_n_output,
  output logic        clock_LP_p_output,
  output logic        clock_LP_n_output,
  output logic [7:0]  clock_hs_output
);

  localparam logic [3:0] S_OFF    = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_STOP   = 4'd2;
  localparam logic [3:0] S_LPX    = 4'd3;
  localparam logic [3:0] S_PREP   = 4'd4;
  localparam logic [3:0] S_HSZ    = 4'd5;
  localparam logic [3:0] S_SYNC   = 4'd6;
  localparam logic [3:0] S_DATA   = 4'd7;
  localparam logic [3:0] S_TRAIL  = 4'd8;
  localparam logic [3:0] S_HSIDLE = 4'd9;

  localparam logic [2:0] C_OFF   = 3'd0;
  localparam logic [2:0] C_STOP  = 3'd1;
  localparam logic [2:0] C_LPX   = 3'd2;
  localparam logic [2:0] C_PREP  = 3'd3;
  localparam logic [2:0] C_HS    = 3'd4;
  localparam logic [2:0] C_TRAIL = 3'd5;

  logic [3:0]  st_q, st_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  cst_q, cst_d;
  logic [7:0]  ccnt_q, ccnt_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  strb_q, strb_d;
  logic        last_q, last_d;
  logic [1:0]  lanes_q, lanes_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [1:0]  rot_q, rot_d;
  logic [3:0]  lbit_q, lbit_d;

  logic        wr_ok;
  logic [2:0]  n_lanes, nvalid, avail, issue, rot_sum;
  logic        word_done;
  logic [3:0]  lane_act, has_byte;
  logic [7:0]  lane_byte [4];

  assign lines_ready = (st_q != S_OFF) && (st_q != S_INIT);
  assign clock_ready = (cst_q == C_HS);
  assign wr_ok       = iface_write_rqst && clock_ready;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_OFF;
      cnt_q   <= '0;
      cst_q   <= C_OFF;
      ccnt_q  <= '0;
      word_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      lanes_q <= '0;
      ptr_q   <= '0;
      rot_q   <= '0;
      lbit_q  <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      cst_q   <= cst_d;
      ccnt_q  <= ccnt_d;
      word_q  <= word_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      lanes_q <= lanes_d;
      ptr_q   <= ptr_d;
      rot_q   <= rot_d;
      lbit_q  <= lbit_d;
    end
  end

  // A cycle only ever issues bytes from the current word; the lane rotation carries over.
  always_comb begin
    n_lanes = {1'b0, lanes_q} + 3'd1;
    case (strb_q)
      4'hf:    nvalid = 3'd4;
      4'h7:    nvalid = 3'd3;
      4'h3:    nvalid = 3'd2;
      default: nvalid = 3'd1;
    endcase
    avail     = nvalid - ptr_q;
    issue     = (avail < n_lanes) ? avail : n_lanes;
    word_done = ((ptr_q + issue) == nvalid);
    rot_sum   = {1'b0, rot_q} + issue;
  end

  always_comb begin
    logic [2:0] j;
    logic [1:0] idx;
    j   = '0;
    idx = '0;
    for (int k = 0; k < 4; k++) begin
      lane_act[k] = (3'(k) <= {1'b0, lanes_q});
      if (3'(k) >= {1'b0, rot_q}) j = 3'(k) - {1'b0, rot_q};
      else                        j = 3'(k) + n_lanes - {1'b0, rot_q};
      idx          = ptr_q[1:0] + j[1:0];
      lane_byte[k] = word_q[{idx, 3'b000} +: 8];
      has_byte[k]  = (st_q == S_DATA) && lane_act[k] && (j < issue);
    end
  end

  always_comb begin
    logic cap_pkt, cap_word;
    st_d    = st_q;
    cnt_d   = cnt_q + 8'd1;
    word_d  = word_q;
    strb_d  = strb_q;
    last_d  = last_q;
    lanes_d = lanes_q;
    ptr_d   = ptr_q;
    rot_d   = rot_q;
    lbit_d  = lbit_q;
    cap_pkt  = 1'b0;
    cap_word = 1'b0;
    iface_data_rqst = 1'b0;
    case (st_q)
      S_OFF:  if (lines_enable) begin st_d = S_INIT; cnt_d = '0; end
      S_INIT: if (cnt_q == 8'(T_INIT - 1)) begin st_d = S_STOP; cnt_d = '0; end
      S_STOP: begin
        if (wr_ok) begin
          cap_pkt = 1'b1;
          st_d    = S_LPX;
          cnt_d   = '0;
        end else if (!lines_enable && cst_q == C_OFF) begin
          st_d = S_OFF;
        end
      end
      S_LPX:  if (cnt_q == 8'(T_LPX - 1)) begin st_d = S_PREP; cnt_d = '0; end
      S_PREP: if (cnt_q == 8'(T_LPX - 1)) begin st_d = S_HSZ; cnt_d = '0; end
      S_HSZ:  if (cnt_q == 8'(T_HS_ZERO - 1)) begin st_d = S_SYNC; cnt_d = '0; end
      S_SYNC: begin
        st_d   = S_DATA;
        ptr_d  = '0;
        rot_d  = '0;
        lbit_d = 4'hf;
      end
      S_DATA: begin
        for (int k = 0; k < 4; k++)
          if (has_byte[k]) lbit_d[k] = lane_byte[k][7];
        rot_d = (rot_sum >= n_lanes) ? 2'(rot_sum - n_lanes) : rot_sum[1:0];
        if (!word_done) begin
          ptr_d = ptr_q + issue;
        end else begin
          ptr_d = '0;
          cnt_d = '0;
          if (!last_q) begin
            iface_data_rqst = 1'b1;
            cap_word        = 1'b1;
          end else begin
`ifdef DSI_LANES_CTRL_TRAIL_EN
            st_d = S_TRAIL;
`else
            st_d = iface_lpm_en ? S_STOP : S_HSIDLE;
`endif
          end
        end
      end
      S_TRAIL: if (cnt_q == 8'(T_TRAIL - 1)) begin
        st_d  = iface_lpm_en ? S_STOP : S_HSIDLE;
        cnt_d = '0;
      end
      S_HSIDLE: if (wr_ok) begin
        cap_pkt = 1'b1;
        st_d    = S_HSZ;
        cnt_d   = '0;
      end
      default: st_d = S_OFF;
    endcase
    if (cap_pkt) lanes_d = reg_lanes_number;
    if (cap_pkt || cap_word) begin
      word_d = iface_write_data;
      strb_d = iface_write_strb;
      last_d = iface_last_word;
    end
  end

  always_comb begin
    LP_p_output    = '0;
    LP_n_output    = '0;
    hs_lane_output = '0;
    for (int k = 0; k < 4; k++) begin
      if (st_q == S_OFF) begin
        LP_p_output[k] = 1'b0;
      end else if (st_q == S_INIT || st_q == S_STOP || !lane_act[k]) begin
        LP_p_output[k] = 1'b1;
        LP_n_output[k] = 1'b1;
      end else begin
        case (st_q)
          S_LPX:  LP_n_output[k] = 1'b1;
          S_SYNC: hs_lane_output[8*k +: 8] = 8'hB8;
          S_DATA: hs_lane_output[8*k +: 8] = has_byte[k] ? lane_byte[k] : {8{~lbit_q[k]}};
          S_TRAIL: hs_lane_output[8*k +: 8] = {8{~lbit_q[k]}};
`ifdef DSI_LANES_CTRL_TRAIL_EN
          S_HSIDLE: hs_lane_output[8*k +: 8] = {8{~lbit_q[k]}};
`endif
          default: hs_lane_output[8*k +: 8] = 8'h00;
        endcase
      end
    end
  end

  // The clock lane may only leave HS once the data lanes are back in LP.
  always_comb begin
    cst_d  = cst_q;
    ccnt_d = ccnt_q + 8'd1;
    case (cst_q)
      C_OFF: if (lines_ready && clock_enable) begin cst_d = C_STOP; ccnt_d = '0; end
      C_STOP: begin
        if (clock_enable) begin
          cst_d  = C_LPX;
          ccnt_d = '0;
        end else if (!lines_enable) begin
          cst_d = C_OFF;
        end
      end
      C_LPX:  if (ccnt_q == 8'(T_LPX - 1)) begin cst_d = C_PREP; ccnt_d = '0; end
      C_PREP: if (ccnt_q == 8'(T_LPX - 1)) begin cst_d = C_HS; ccnt_d = '0; end
      C_HS: if (!clock_enable && ((st_q == S_STOP && !wr_ok) || st_q == S_OFF)) begin
        cst_d  = C_TRAIL;
        ccnt_d = '0;
      end
      C_TRAIL: if (ccnt_q == 8'(T_TRAIL - 1)) begin cst_d = C_STOP; ccnt_d = '0; end
      default: cst_d = C_OFF;
    endcase
  end

  always_comb begin
    clock_LP_p_output = 1'b0;
    clock_LP_n_output = 1'b0;
    clock_hs_output   = 8'h00;
    case (cst_q)
      C_STOP: begin clock_LP_p_output = 1'b1; clock_LP_n_output = 1'b1; end
      C_LPX:  clock_LP_n_output = 1'b1;
      C_HS:   clock_hs_output = 8'hAA;
      default: clock_hs_output = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_dsi_lanes_ctrl.sv
// Directed bench for dsi_lanes_ctrl: init, clock bring-up, 4/1/2-lane packets, LPM off, async reset.
module tb_dsi_lanes_ctrl;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_rqst, iface_last_word, iface_data_rqst, iface_lpm_en;
  logic [1:0]  reg_lanes_number;
  logic        lines_enable, clock_enable, lines_ready, clock_ready;
  logic [31:0] hs_lane_output;
  logic [3:0]  LP_p_output, LP_n_output;
  logic        clock_LP_p_output, clock_LP_n_output;
  logic [7:0]  clock_hs_output;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef DSI_LANES_CTRL_TRAIL_EN
  localparam logic [31:0] P3_IDLE = 32'h0000FF00;
`else
  localparam logic [31:0] P3_IDLE = 32'h00000000;
`endif

  dsi_lanes_ctrl dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .iface_write_data(iface_write_data), .iface_write_strb(iface_write_strb),
    .iface_write_rqst(iface_write_rqst), .iface_last_word(iface_last_word),
    .iface_data_rqst(iface_data_rqst), .iface_lpm_en(iface_lpm_en),
    .reg_lanes_number(reg_lanes_number), .lines_enable(lines_enable),
    .clock_enable(clock_enable), .lines_ready(lines_ready), .clock_ready(clock_ready),
    .hs_lane_output(hs_lane_output), .LP_p_output(LP_p_output), .LP_n_output(LP_n_output),
    .clock_LP_p_output(clock_LP_p_output), .clock_LP_n_output(clock_LP_n_output),
    .clock_hs_output(clock_hs_output)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_n(input string tag, input int n, input logic [3:0] ep,
                          input logic [3:0] en, input logic [31:0] ehs);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_lp"}, {24'h0, LP_p_output, LP_n_output}, {24'h0, ep, en});
      chk({tag, "_hs"}, hs_lane_output, ehs);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iface_write_data = '0; iface_write_strb = '0; iface_write_rqst = 1'b0;
    iface_last_word = 1'b0; iface_lpm_en = 1'b1; reg_lanes_number = 2'd3;
    lines_enable = 1'b0; clock_enable = 1'b0;
    step(); step();
    chk("rst_lp", {24'h0, LP_p_output, LP_n_output}, 32'h0);
    chk("rst_hs", hs_lane_output, 32'h0);
    chk("rst_clk", {22'h0, clock_LP_p_output, clock_LP_n_output, clock_hs_output}, 32'h0);
    chk("rst_flags", {29'h0, lines_ready, clock_ready, iface_data_rqst}, 32'h0);

    rst_n = 1'b1; lines_enable = 1'b1;
    step();
    chk("init_lp", {24'h0, LP_p_output, LP_n_output}, 32'h0000_00FF);
    chk("init_ready", {31'h0, lines_ready}, 32'h0);
    repeat (99) step();
    chk("init_ready_99", {31'h0, lines_ready}, 32'h0);
    step();
    chk("init_ready_100", {31'h0, lines_ready}, 32'h1);

    clock_enable = 1'b1;
    step();
    chk("clk_stop", {30'h0, clock_LP_p_output, clock_LP_n_output}, 32'h3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("clk_lpx", {30'h0, clock_LP_p_output, clock_LP_n_output}, 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("clk_prep", {22'h0, clock_LP_p_output, clock_LP_n_output, clock_hs_output}, 32'h0);
    end
    step();
    chk("clk_hs", {24'h0, clock_hs_output}, 32'hAA);
    chk("clk_ready", {31'h0, clock_ready}, 32'h1);

    // Packet 1: four lanes, three full words.
    iface_lpm_en = 1'b1; reg_lanes_number = 2'd3;
    iface_write_data = 32'h4433_2211; iface_write_strb = 4'hf; iface_last_word = 1'b0;
    iface_write_rqst = 1'b1;
    expect_n("p1_lpx", 4, 4'h0, 4'hF, 32'h0);
    iface_write_rqst = 1'b0;
    expect_n("p1_prep", 4, 4'h0, 4'h0, 32'h0);
    expect_n("p1_hsz", 6, 4'h0, 4'h0, 32'h0);
    expect_n("p1_sync", 1, 4'h0, 4'h0, 32'hB8B8_B8B8);
    expect_n("p1_w0", 1, 4'h0, 4'h0, 32'h4433_2211);
    chk("p1_rqst0", {31'h0, iface_data_rqst}, 32'h1);
    iface_write_data = 32'h8877_6655;
    expect_n("p1_w1", 1, 4'h0, 4'h0, 32'h8877_6655);
    chk("p1_rqst1", {31'h0, iface_data_rqst}, 32'h1);
    iface_write_data = 32'h7F80_01FE; iface_last_word = 1'b1;
    expect_n("p1_w2", 1, 4'h0, 4'h0, 32'h7F80_01FE);
    chk("p1_rqst2", {31'h0, iface_data_rqst}, 32'h0);
    iface_last_word = 1'b0;
`ifdef DSI_LANES_CTRL_TRAIL_EN
    expect_n("p1_trail", 4, 4'h0, 4'h0, 32'hFF00_FF00);
`endif
    expect_n("p1_stop", 1, 4'hF, 4'hF, 32'h0);

    // Packet 2: one lane, two bytes; lane count change mid-packet is ignored.
    reg_lanes_number = 2'd0;
    iface_write_data = 32'hA5C3_5A81; iface_write_strb = 4'h3; iface_last_word = 1'b1;
    iface_write_rqst = 1'b1;
    expect_n("p2_lpx", 4, 4'hE, 4'hF, 32'h0);
    iface_write_rqst = 1'b0; reg_lanes_number = 2'd3; iface_last_word = 1'b0;
    expect_n("p2_prep", 4, 4'hE, 4'hE, 32'h0);
    expect_n("p2_hsz", 6, 4'hE, 4'hE, 32'h0);
    expect_n("p2_sync", 1, 4'hE, 4'hE, 32'h0000_00B8);
    expect_n("p2_b0", 1, 4'hE, 4'hE, 32'h0000_0081);
    chk("p2_rqst0", {31'h0, iface_data_rqst}, 32'h0);
    expect_n("p2_b1", 1, 4'hE, 4'hE, 32'h0000_005A);
    chk("p2_rqst1", {31'h0, iface_data_rqst}, 32'h0);
`ifdef DSI_LANES_CTRL_TRAIL_EN
    expect_n("p2_trail", 4, 4'hE, 4'hE, 32'h0000_00FF);
`endif
    expect_n("p2_stop", 1, 4'hF, 4'hF, 32'h0);

    // Packet 3: two lanes, three bytes, lanes stay in HS afterwards.
    iface_lpm_en = 1'b0; reg_lanes_number = 2'd1;
    iface_write_data = 32'h00B3_2211; iface_write_strb = 4'h7; iface_last_word = 1'b1;
    iface_write_rqst = 1'b1;
    expect_n("p3_lpx", 4, 4'hC, 4'hF, 32'h0);
    iface_write_rqst = 1'b0; iface_last_word = 1'b0;
    expect_n("p3_prep", 4, 4'hC, 4'hC, 32'h0);
    expect_n("p3_hsz", 6, 4'hC, 4'hC, 32'h0);
    expect_n("p3_sync", 1, 4'hC, 4'hC, 32'h0000_B8B8);
    expect_n("p3_c0", 1, 4'hC, 4'hC, 32'h0000_2211);
    expect_n("p3_c1", 1, 4'hC, 4'hC, 32'h0000_FFB3);
`ifdef DSI_LANES_CTRL_TRAIL_EN
    expect_n("p3_trail", 4, 4'hC, 4'hC, 32'h0000_FF00);
`endif
    expect_n("p3_idle", 2, 4'hC, 4'hC, P3_IDLE);

    clock_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("clk_hold_hs", {23'h0, clock_ready, clock_hs_output}, 32'h1AA);
    end
    clock_enable = 1'b1;

    // Second packet from HS idle skips the LP request sequence.
    iface_write_data = 32'hDDCC_BBAA; iface_write_strb = 4'hf; iface_last_word = 1'b0;
    iface_write_rqst = 1'b1;
    expect_n("p3b_hsz", 6, 4'hC, 4'hC, 32'h0);
    iface_write_rqst = 1'b0;
    expect_n("p3b_sync", 1, 4'hC, 4'hC, 32'h0000_B8B8);
    expect_n("p3b_d0", 1, 4'hC, 4'hC, 32'h0000_BBAA);
    chk("p3b_rqst", {31'h0, iface_data_rqst}, 32'h0);

    rst_n = 1'b0;
    #1;
    chk("arst_lp", {24'h0, LP_p_output, LP_n_output}, 32'h0);
    chk("arst_hs", hs_lane_output, 32'h0);
    chk("arst_clk", {22'h0, clock_LP_p_output, clock_LP_n_output, clock_hs_output}, 32'h0);
    chk("arst_flags", {29'h0, lines_ready, clock_ready, iface_data_rqst}, 32'h0);

    lines_enable = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("off_lp", {24'h0, LP_p_output, LP_n_output}, 32'h0);
    chk("off_ready", {30'h0, lines_ready, clock_ready}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dsi_lanes_ctrl.md
DSI_LANES_CTRL -- requirements
Module: dsi_lanes_ctrl

Interface
REQ-001 T_INIT, 100, clk_sys cycles data lanes hold LP-11 after lines_enable before lines_ready.
REQ-002 T_LPX, 4, cycles per LP-01 and LP-00 request state.
REQ-003 T_HS_ZERO, 6, cycles of HS-zero (all-0 bytes) before sync byte.
REQ-004 T_TRAIL, 4, cycles of HS-trail.
REQ-005 clk_sys  in  1  sole clock; one HS byte per active lane per cycle.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 iface_write_data  in  32  packet word; byte0 = [7:0] sent first.
REQ-008 iface_write_strb  in  4  valid bytes, LSB-contiguous (f,7,3,1).
REQ-009 iface_write_rqst  in  1  one-cycle pulse: start packet, first word valid.
REQ-010 iface_last_word  in  1  qualifies the word captured with it as final.
REQ-011 iface_data_rqst  out  1  one-cycle pulse requesting next word.
REQ-012 iface_lpm_en  in  1  1 = return lanes to LP-11 after each packet.
REQ-013 reg_lanes_number  in  2  active lanes minus 1 (0..3).
REQ-014 lines_enable / clock_enable  in  1 each  data-lane / clock-lane enables.
REQ-015 lines_ready / clock_ready  out  1 each  lanes initialised / clock in HS.
REQ-016 hs_lane_output  out  32  byte per lane, lane k = [8k+7:8k], to external serializer.
REQ-017 LP_p_output, LP_n_output  out  4 each  data lane LP levels.
REQ-018 clock_LP_p_output, clock_LP_n_output  out  1 each; clock_hs_output  out  8  clock byte pattern.

Function
REQ-019 Data lane FSM: OFF -> INIT -> STOP(LP-11) -> LPX(LP-01) -> PREP(LP-00) -> HS_ZERO -> SYNC -> DATA -> TRAIL -> STOP.
REQ-020 OFF: LP=00, hs=0; lines_enable=1 enters INIT (LP-11); after T_INIT cycles lines_ready=1, STOP.
REQ-021 Clock FSM: OFF -> STOP -> LPX -> PREP -> HS; clock_enable rising (lines_ready=1) starts it; clock_ready=1 in HS, clock_hs_output=8'hAA in HS, 0 otherwise.
REQ-022 clock_enable=0 in HS: clock HS-trail T_TRAIL cycles (8'h00), then LP-11, clock_ready=0; ignored while data lanes not in STOP/OFF until they return.
REQ-023 iface_write_rqst in STOP with clock_ready=1 captures word/strb/last_word; ignored otherwise.
REQ-024 Active lanes (0..reg_lanes_number) run LP sequence, T_HS_ZERO cycles 8'h00, one cycle 8'hB8, then DATA; inactive lanes stay LP-11, hs=0.
REQ-025 DATA: each cycle byte i of stream goes to lane i mod N (N=reg_lanes_number+1); only strobed bytes sent.
REQ-026 When a non-last word's last byte is issued, iface_data_rqst pulses that cycle; next word captured at following edge; no bubble on lanes.
REQ-027 After last word's final byte, lanes with no byte that cycle send complement of their last bit repeated; all go TRAIL.
REQ-028 TRAIL: each lane sends bytes of inverted last-sent bit for T_TRAIL cycles, then LP-11 if iface_lpm_en=1.
REQ-029 iface_lpm_en=0: after TRAIL lanes remain HS sending trail bytes; next iface_write_rqst goes directly to HS_ZERO.
REQ-030 lines_enable=0 honoured only in STOP: -> OFF, lines_ready=0; clock must be OFF first.
REQ-031 reg_lanes_number sampled at iface_write_rqst; changes mid-packet ignored.

Reset
REQ-032 rst_n=0: all FSMs OFF, LP/hs outputs 0, ready and iface_data_rqst 0, capture regs cleared, immediately.
REQ-033 Reset mid-packet aborts; no trail emitted.

Configuration
REQ-034 DSI_LANES_CTRL_TRAIL_EN defined: TRAIL state per REQ-027/028; undefined: TRAIL skipped, lanes go to STOP (or hold 00 bytes if lpm_en=0) after last byte.

Verification
REQ-035 Reset, lines_enable=1 -> LP-11 on 4 lanes, lines_ready=1 after 100 cycles.
REQ-036 clock_enable=1 -> clock LP 11,01(4),00(4), then 8'hAA, clock_ready=1.
REQ-037 4 lanes, 3 words strb f, last on word 3 -> each lane: 00 x6, B8, 3 data bytes; data_rqst pulses twice; trail; LP-11.
REQ-038 reg_lanes_number=0, one word strb 3 -> lane0 sends B8, byte0, byte1; lanes1-3 LP-11.
REQ-039 iface_lpm_en=0 -> lanes stay HS after trail; second packet skips LP sequence.
REQ-040 rst_n low during DATA -> all outputs 0 same cycle, FSMs OFF.
